// File: rtl/ifft_reorder_cp.sv
// ifft_reorder_cp: bit-reversed to natural reorder through a ping-pong RAM, cyclic-prefix insertion, ready/valid output with sticky overflow/sync-error flags
module ifft_reorder_cp #(
  parameter int DW = 16,
  parameter int LGMAX = 8,
  parameter int LGMIN = 3
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_ce,
  input  logic [2*DW-1:0] i_sample,
  input  logic            i_sync,
  input  logic [3:0]      i_lgsize,
  input  logic [LGMAX:0]  i_cplen,
  output logic [2*DW-1:0] o_result,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_sync,
  output logic            o_overflow,
  output logic            o_syncerr
);
  localparam int AW = LGMAX;
  localparam int CW = LGMAX + 1;
  typedef enum logic {W_WAIT, W_FILL} wst_t;
  typedef enum logic [1:0] {R_IDLE, R_CP, R_BODY} rst_t;
  logic [2*DW-1:0] mem [2**(AW+1)];
  wst_t wst_q, wst_d;
  rst_t rst_q, rst_d;
  logic [1:0] full_q, full_d;
  logic [3:0] lg_q [2];
  logic [CW-1:0] cp_q [2];
  logic wbank_q, wbank_d, rbank_q, rbank_d;
  logic [AW-1:0] k_q, k_d, rcnt_q, rcnt_d;
  logic [3:0] wlg_q, wlg_d;
  logic ovf_q, ovf_d, serr_q, serr_d;
  logic [2*DW-1:0] ram_q;
  logic rv_q, rs_q;
  logic [2*DW:0] f_q [2];
  logic wp_q, rp_q;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] lg_c;
  logic [CW-1:0] n_c, cp_c, wn, rn, rcp;
  logic [AW-1:0] rev, waddr, raddr;
  logic wfree, start, wadv, wlast, we, pop, adv, cp_last, body_last, rel, rsync;
  always_comb begin
    lg_c = i_lgsize < 4'(LGMIN) ? 4'(LGMIN) : i_lgsize > 4'(LGMAX) ? 4'(LGMAX) : i_lgsize;
    n_c = CW'(1) << lg_c;
    cp_c = i_cplen > n_c ? n_c : i_cplen;
  end
  always_comb begin
    rn = CW'(1) << lg_q[rbank_q];
    rcp = cp_q[rbank_q];
    pop = o_valid && i_ready;
    adv = rst_q != R_IDLE && (cnt_q + 2'(rv_q) < 2'd2 || pop);
    cp_last = rst_q == R_CP && rcnt_q == AW'(rcp - CW'(1));
    body_last = rst_q == R_BODY && rcnt_q == AW'(rn - CW'(1));
    rel = adv && body_last;
    rst_d = rst_q;
    rbank_d = rbank_q;
    rcnt_d = rcnt_q;
    if (rst_q == R_IDLE && full_q[rbank_q]) begin
      rst_d = rcp != '0 ? R_CP : R_BODY;
      rcnt_d = '0;
    end else if (adv) begin
      rcnt_d = cp_last || body_last ? '0 : rcnt_q + AW'(1);
      rst_d = cp_last ? R_BODY : !body_last ? rst_q : !full_q[~rbank_q] ? R_IDLE : cp_q[~rbank_q] != '0 ? R_CP : R_BODY;
      rbank_d = rbank_q ^ body_last;
    end
  end
  always_comb begin
    raddr = rst_q == R_CP ? AW'(rn - rcp + CW'(rcnt_q)) : rcnt_q;
    rsync = rcnt_q == '0 && (rst_q == R_CP || rcp == '0);
  end
  always_comb begin
    wn = CW'(1) << wlg_q;
    wfree = !full_q[wbank_q] || (rel && rbank_q == wbank_q);
    start = i_ce && i_sync && (wst_q == W_FILL || wfree);
    wadv = wst_q == W_FILL && i_ce && !i_sync;
    wlast = wadv && k_q == AW'(wn - CW'(1));
    wst_d = start ? W_FILL : wlast ? W_WAIT : wst_q;
    wbank_d = wbank_q ^ wlast;
    k_d = start ? AW'(1) : wadv ? k_q + AW'(1) : k_q;
    wlg_d = start ? lg_c : wlg_q;
    ovf_d = ovf_q || (i_ce && i_sync && wst_q == W_WAIT && !wfree);
    serr_d = serr_q || (i_ce && i_sync && wst_q == W_FILL);
    full_d = full_q;
    if (wlast) full_d[wbank_q] = 1'b1;
    if (rel) full_d[rbank_q] = 1'b0;
  end
  always_comb begin
    for (int i = 0; i < AW; i++) rev[i] = k_q[AW-1-i];
    we = start || wadv;
    waddr = start ? '0 : rev >> (4'(LGMAX) - wlg_q);
  end
  always_comb begin
    cnt_d = cnt_q + 2'(rv_q) - 2'(pop);
    o_valid = cnt_q != '0;
    o_result = f_q[rp_q][2*DW-1:0];
    o_sync = o_valid && f_q[rp_q][2*DW];
    o_overflow = ovf_q;
    o_syncerr = serr_q;
  end
  always_ff @(posedge i_clk) begin
    if (we) mem[{wbank_q, waddr}] <= i_sample;
    ram_q <= mem[{rbank_q, raddr}];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wst_q <= W_WAIT;
      rst_q <= R_IDLE;
      full_q <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      k_q <= '0;
      rcnt_q <= '0;
      wlg_q <= 4'(LGMIN);
      ovf_q <= 1'b0;
      serr_q <= 1'b0;
      rv_q <= 1'b0;
      rs_q <= 1'b0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= '0;
      f_q[0] <= '0;
      f_q[1] <= '0;
      lg_q[0] <= 4'(LGMIN);
      lg_q[1] <= 4'(LGMIN);
      cp_q[0] <= '0;
      cp_q[1] <= '0;
    end else begin
      wst_q <= wst_d;
      rst_q <= rst_d;
      full_q <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      k_q <= k_d;
      rcnt_q <= rcnt_d;
      wlg_q <= wlg_d;
      ovf_q <= ovf_d;
      serr_q <= serr_d;
      rv_q <= adv;
      rs_q <= rsync;
      cnt_q <= cnt_d;
      wp_q <= wp_q ^ rv_q;
      rp_q <= rp_q ^ pop;
      if (rv_q) f_q[wp_q] <= {rs_q, ram_q};
      if (start) begin
        lg_q[wbank_q] <= lg_c;
        cp_q[wbank_q] <= cp_c;
      end
    end
  end
endmodule

// File: tb/tb_ifft_reorder_cp.sv
// tb_ifft_reorder_cp: randomized scoreboard bench for ifft_reorder_cp
module tb_ifft_reorder_cp;
  localparam int DW = 16;
  localparam int LGMAX = 8;
  localparam int LGMIN = 3;
  localparam int CW = LGMAX + 1;
  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_ce = 1'b0;
  logic i_sync = 1'b0;
  logic i_ready = 1'b0;
  logic [2*DW-1:0] i_sample = '0;
  logic [3:0] i_lgsize = '0;
  logic [CW-1:0] i_cplen = '0;
  logic [2*DW-1:0] o_result;
  logic o_valid, o_sync, o_overflow, o_syncerr;
  int n_chk = 0, n_pass = 0, cyc = 0, acc_cnt = 0, t_last = 0, rmode = 0, pat = 0;
  logic [2*DW:0] exp_q [$];
  logic [2*DW:0] e;
  ifft_reorder_cp #(.DW(DW), .LGMAX(LGMAX), .LGMIN(LGMIN)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_sample(i_sample), .i_sync(i_sync),
    .i_lgsize(i_lgsize), .i_cplen(i_cplen), .o_result(o_result), .o_valid(o_valid),
    .i_ready(i_ready), .o_sync(o_sync), .o_overflow(o_overflow), .o_syncerr(o_syncerr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask
  function automatic int brev(input int k, input int b);
    int r = 0;
    for (int i = 0; i < b; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction
  always @(negedge clk) begin
    if (!i_reset && o_valid) begin
      if (i_ready) begin
        acc_cnt++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data", 64'(o_result), 64'(e[2*DW-1:0]));
          check("sync", 64'(o_sync), 64'(e[2*DW]));
        end
      end else if (exp_q.size() != 0) check("hold", 64'({o_sync, o_result}), 64'(exp_q[0]));
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    i_ready = rmode == 1 ? 1'b1 : rmode == 2 ? 1'($urandom_range(1)) : rmode == 3 ? (pat % 4 == 0 || pat % 4 == 3) : 1'b0;
    pat++;
  end
  task automatic send_frame(input int lg, input int cpr, input int kind, input bit push, input int len, input int gap_pct);
    int lgc, n, cpv, cpc, cnt;
    logic [2*DW-1:0] x [];
    lgc = lg < LGMIN ? LGMIN : lg > LGMAX ? LGMAX : lg;
    n = 1 << lgc;
    cpv = cpr % (1 << CW);
    cpc = cpv > n ? n : cpv;
    x = new[n];
    for (int i = 0; i < n; i++) x[i] = kind == 0 ? 32'(i) : kind == 1 ? 32'(i + 100) : $urandom;
    if (push) begin
      for (int i = n - cpc; i < n; i++) exp_q.push_back({i == n - cpc, x[i]});
      for (int i = 0; i < n; i++) exp_q.push_back({i == 0 && cpc == 0, x[i]});
    end
    cnt = len < 0 ? n : len;
    for (int k = 0; k < cnt; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        i_ce = 1'b0;
        i_sync = 1'b0;
        @(posedge clk);
        #1;
      end
      i_ce = 1'b1;
      i_sync = k == 0;
      i_lgsize = k == 0 ? 4'(lg) : 4'($urandom);
      i_cplen = k == 0 ? CW'(cpr) : CW'($urandom);
      i_sample = x[brev(k, lgc)];
      t_last = cyc + 1;
      @(posedge clk);
      #1;
    end
    i_ce = 1'b0;
    i_sync = 1'b0;
  endtask
  task automatic drain(input string tag, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(tag, 64'(exp_q.size()), 0);
    exp_q.delete();
    repeat (30) @(posedge clk);
    #1;
  endtask
  initial begin
    int c, gaps;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(o_valid), 0);
    check("rst_sync", 64'(o_sync), 0);
    check("rst_result", 64'(o_result), 0);
    check("rst_ovf", 64'(o_overflow), 0);
    check("rst_serr", 64'(o_syncerr), 0);
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rmode = 1;
    acc_cnt = 0;
    send_frame(6, 16, 0, 1, -1, 0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!o_valid && c < 20);
    check("latency", 64'(cyc - t_last), 3);
    @(posedge clk);
    #1;
    drain("t1_drain", 2000);
    check("t1_count", 64'(acc_cnt), 80);
    acc_cnt = 0;
    gaps = 0;
    fork
      begin
        send_frame(6, 16, 0, 1, -1, 0);
        send_frame(6, 16, 1, 1, -1, 0);
      end
      begin
        c = 0;
        do begin
          @(negedge clk);
          c++;
        end while (!o_valid && c < 300);
        for (int i = 1; i < 160; i++) begin
          @(negedge clk);
          if (!o_valid) gaps++;
        end
      end
    join
    check("t2_gaps", 64'(gaps), 0);
    @(posedge clk);
    #1;
    drain("t2_drain", 2000);
    check("t2_count", 64'(acc_cnt), 160);
    rmode = 3;
    pat = 0;
    acc_cnt = 0;
    send_frame(3, 0, 0, 1, -1, 0);
    drain("t3_drain", 500);
    check("t3_count", 64'(acc_cnt), 8);
    rmode = 0;
    acc_cnt = 0;
    check("t4_ovf_before", 64'(o_overflow), 0);
    send_frame(6, 16, 0, 1, -1, 0);
    send_frame(6, 16, 1, 1, -1, 0);
    send_frame(6, 16, 2, 0, -1, 0);
    repeat (10) @(posedge clk);
    #1;
    check("t4_ovf", 64'(o_overflow), 1);
    rmode = 1;
    drain("t4_drain", 3000);
    check("t4_count", 64'(acc_cnt), 160);
    acc_cnt = 0;
    check("t5_serr_before", 64'(o_syncerr), 0);
    send_frame(6, 8, 2, 0, 20, 0);
    send_frame(6, 8, 1, 1, -1, 0);
    check("t5_serr", 64'(o_syncerr), 1);
    drain("t5_drain", 2000);
    check("t5_count", 64'(acc_cnt), 72);
    acc_cnt = 0;
    send_frame(15, 999, 2, 1, -1, 0);
    drain("t6_drain", 3000);
    check("t6_count", 64'(acc_cnt), 512);
    rmode = 2;
    for (int p = 0; p < 5; p++) begin
      send_frame($urandom_range(15), $urandom_range(511), 2, 1, -1, 20);
      send_frame($urandom_range(15), $urandom_range(511), 2, 1, -1, 20);
      drain("t7_drain", 20000);
    end
    rmode = 1;
    send_frame(6, 16, 2, 1, -1, 0);
    repeat (12) @(posedge clk);
    #1;
    check("t8_valid_pre", 64'(o_valid), 1);
    check("t8_ovf_pre", 64'(o_overflow), 1);
    check("t8_serr_pre", 64'(o_syncerr), 1);
    i_reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(negedge clk);
    check("t8_valid", 64'(o_valid), 0);
    check("t8_sync", 64'(o_sync), 0);
    check("t8_ovf", 64'(o_overflow), 0);
    check("t8_serr", 64'(o_syncerr), 0);
    @(posedge clk);
    #1;
    acc_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    check("t8_no_stale", 64'(acc_cnt), 0);
    send_frame(4, 5, 2, 1, -1, 0);
    drain("t8_drain", 500);
    check("t8_count", 64'(acc_cnt), 21);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
